// File: rtl/mem_bus_switch.sv
// mem_bus_switch
// Shares the single main-memory port between the data cache and the
// instruction cache. Each cycle one requester is granted, and its command is
// forwarded to memory. The memory acceptance tag goes back to the winner only.
// A 15-entry owner table, indexed by tag, records which cache owns each
// in-flight tag, so that each completion can be steered to its owner.
//
// Ports
//   clock, reset                 clock, asynchronous active-low reset
//   dcache2ctlr_command/addr/data dcache request (load or store)
//   icache2ctlr_command/addr      icache request (load only)
//   Ctlr2proc_response/data/tag   dcache acceptance tag, return data, completion tag
//   Ctlr2icache_response/data/tag icache acceptance tag, return data, completion tag
//   proc2mem_command/addr/data    command to memory
//   mem2proc_response/data/tag    memory acceptance tag, return data, completion tag
//   dcache_outstanding            count of dcache-owned tags in flight
//   icache_outstanding            count of icache-owned tags in flight
//   tag_err                       sticky: stray completion or re-accepted live tag

`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_switch #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        dcache2ctlr_command,
   input  logic [`XLEN-1:0]  dcache2ctlr_addr,
   input  logic [63:0]       dcache2ctlr_data,
   input  logic [1:0]        icache2ctlr_command,
   input  logic [`XLEN-1:0]  icache2ctlr_addr,
   output logic [3:0]        Ctlr2proc_response,
   output logic [63:0]       Ctlr2proc_data,
   output logic [3:0]        Ctlr2proc_tag,
   output logic [3:0]        Ctlr2icache_response,
   output logic [63:0]       Ctlr2icache_data,
   output logic [3:0]        Ctlr2icache_tag,
   output logic [1:0]        proc2mem_command,
   output logic [`XLEN-1:0]  proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   input  logic [3:0]        mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [3:0]        mem2proc_tag,
   output logic [3:0]        dcache_outstanding,
   output logic [3:0]        icache_outstanding,
   output logic              tag_err
);

   localparam logic [1:0] BUS_NONE = 2'd0;

   // Table bit 0 is never set, because tag 0 means "no tag".
   // owner = 1 marks an icache-owned tag.
   logic [15:0] valid_q, valid_d;
   logic [15:0] owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic [3:0]  dc_cnt_q, dc_cnt_d;
   logic [3:0]  ic_cnt_q, ic_cnt_d;
   logic        tag_err_q, tag_err_d;

   logic dc_req, ic_req, dc_win, ic_win;
   logic acc, cmp_hit, cmp_own, ovw, ovw_own;

   always_comb begin
      dc_req = dcache2ctlr_command != BUS_NONE;
      ic_req = icache2ctlr_command != BUS_NONE;
      ic_win = ic_req && (!dc_req || (starve_q >= 4'(STARVE_LIMIT)));
      dc_win = dc_req && !ic_win;

      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (dc_win) begin
         proc2mem_command = dcache2ctlr_command;
         proc2mem_addr    = dcache2ctlr_addr;
         proc2mem_data    = dcache2ctlr_data;
      end else if (ic_win) begin
         proc2mem_command = icache2ctlr_command;
         proc2mem_addr    = icache2ctlr_addr;
      end
      Ctlr2proc_response   = dc_win ? mem2proc_response : 4'd0;
      Ctlr2icache_response = ic_win ? mem2proc_response : 4'd0;

      // A completion is steered by the owner recorded before this edge.
      cmp_hit          = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
      cmp_own          = owner_q[mem2proc_tag];
      Ctlr2proc_tag    = (cmp_hit && !cmp_own) ? mem2proc_tag  : 4'd0;
      Ctlr2proc_data   = (cmp_hit && !cmp_own) ? mem2proc_data : 64'd0;
      Ctlr2icache_tag  = (cmp_hit &&  cmp_own) ? mem2proc_tag  : 4'd0;
      Ctlr2icache_data = (cmp_hit &&  cmp_own) ? mem2proc_data : 64'd0;

      // Re-accepting a live tag is illegal unless that tag completes in the
      // same cycle. In the legal case the old entry is retired first.
      acc     = (dc_win || ic_win) && (mem2proc_response != 4'd0);
      ovw     = acc && valid_q[mem2proc_response] &&
                !(cmp_hit && (mem2proc_tag == mem2proc_response));
      ovw_own = owner_q[mem2proc_response];

      valid_d = valid_q;
      owner_d = owner_q;
      if (cmp_hit) valid_d[mem2proc_tag] = 1'b0;
      if (acc) begin
         valid_d[mem2proc_response] = 1'b1;
         owner_d[mem2proc_response] = ic_win;
      end

      // Two decrements can land on one counter in a single cycle: a
      // completion plus an overwrite of another tag with the same owner.
      dc_cnt_d = dc_cnt_q + {3'd0, acc && dc_win}
                          - {3'd0, cmp_hit && !cmp_own}
                          - {3'd0, ovw && !ovw_own};
      ic_cnt_d = ic_cnt_q + {3'd0, acc && ic_win}
                          - {3'd0, cmp_hit && cmp_own}
                          - {3'd0, ovw && ovw_own};

      tag_err_d = tag_err_q || ((mem2proc_tag != 4'd0) && !cmp_hit) || ovw;

      if (ic_req && !ic_win) starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
      else                   starve_d = 4'd0;

      dcache_outstanding = dc_cnt_q;
      icache_outstanding = ic_cnt_q;
      tag_err            = tag_err_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         owner_q   <= '0;
         starve_q  <= '0;
         dc_cnt_q  <= '0;
         ic_cnt_q  <= '0;
         tag_err_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         owner_q   <= owner_d;
         starve_q  <= starve_d;
         dc_cnt_q  <= dc_cnt_d;
         ic_cnt_q  <= ic_cnt_d;
         tag_err_q <= tag_err_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_switch.sv
module tb_mem_bus_switch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  dcmd, icmd;
   logic [31:0] daddr, iaddr;
   logic [63:0] ddata, mdata;
   logic [3:0]  mresp, mtag;
   logic [3:0]  d_resp, i_resp, d_tag, i_tag, d_out, i_out;
   logic [63:0] d_data, i_data, p_data;
   logic [1:0]  p_cmd;
   logic [31:0] p_addr;
   logic        terr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   mem_bus_switch #(.STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .dcache2ctlr_command(dcmd), .dcache2ctlr_addr(daddr), .dcache2ctlr_data(ddata),
      .icache2ctlr_command(icmd), .icache2ctlr_addr(iaddr),
      .Ctlr2proc_response(d_resp), .Ctlr2proc_data(d_data), .Ctlr2proc_tag(d_tag),
      .Ctlr2icache_response(i_resp), .Ctlr2icache_data(i_data), .Ctlr2icache_tag(i_tag),
      .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
      .mem2proc_response(mresp), .mem2proc_data(mdata), .mem2proc_tag(mtag),
      .dcache_outstanding(d_out), .icache_outstanding(i_out), .tag_err(terr)
   );

   typedef struct {
      logic [1:0]  dcmd;  logic [31:0] daddr; logic [63:0] ddata;
      logic [1:0]  icmd;  logic [31:0] iaddr;
      logic [3:0]  mresp; logic [3:0]  mtag;  logic [63:0] mdata;
      logic [1:0]  pcmd;  logic [31:0] paddr; logic [63:0] pdata;
      logic [3:0]  dresp; logic [3:0]  iresp;
      logic [3:0]  dtag;  logic [63:0] ddat;
      logic [3:0]  itag;  logic [63:0] idat;
      logic [3:0]  dcnt;  logic [3:0]  icnt; logic err;
   } vec_t;

   function automatic vec_t mk(
      logic [1:0] dc, logic [31:0] da, logic [63:0] dd, logic [1:0] ic, logic [31:0] ia,
      logic [3:0] mr, logic [3:0] mt, logic [63:0] md,
      logic [1:0] pc, logic [31:0] pa, logic [63:0] pd, logic [3:0] dr, logic [3:0] ir,
      logic [3:0] dt, logic [63:0] ddo, logic [3:0] it, logic [63:0] ido,
      logic [3:0] dn, logic [3:0] in_, logic er);
      vec_t v;
      v.dcmd = dc; v.daddr = da; v.ddata = dd; v.icmd = ic; v.iaddr = ia;
      v.mresp = mr; v.mtag = mt; v.mdata = md;
      v.pcmd = pc; v.paddr = pa; v.pdata = pd; v.dresp = dr; v.iresp = ir;
      v.dtag = dt; v.ddat = ddo; v.itag = it; v.idat = ido;
      v.dcnt = dn; v.icnt = in_; v.err = er;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      dcmd = v.dcmd; daddr = v.daddr; ddata = v.ddata;
      icmd = v.icmd; iaddr = v.iaddr;
      mresp = v.mresp; mtag = v.mtag; mdata = v.mdata;
   endtask

   task automatic check_vec(string nm, vec_t v);
      chk({nm, ".pcmd"},  64'(p_cmd),  64'(v.pcmd));
      chk({nm, ".paddr"}, 64'(p_addr), 64'(v.paddr));
      chk({nm, ".pdata"}, p_data,      v.pdata);
      chk({nm, ".dresp"}, 64'(d_resp), 64'(v.dresp));
      chk({nm, ".iresp"}, 64'(i_resp), 64'(v.iresp));
      chk({nm, ".dtag"},  64'(d_tag),  64'(v.dtag));
      chk({nm, ".ddata"}, d_data,      v.ddat);
      chk({nm, ".itag"},  64'(i_tag),  64'(v.itag));
      chk({nm, ".idata"}, i_data,      v.idat);
      chk({nm, ".dcnt"},  64'(d_out),  64'(v.dcnt));
      chk({nm, ".icnt"},  64'(i_out),  64'(v.icnt));
      chk({nm, ".err"},   64'(terr),   64'(v.err));
   endtask

   // Applies reset mid-cycle, which also exercises the asynchronous clear.
   task automatic do_reset(string nm);
      vec_t z;
      z = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0);
      @(negedge clock);
      drive(z);
      #2 reset = 1'b0;
      #1 check_vec(nm, z);
      @(negedge clock);
      reset = 1'b1;
      #1 check_vec({nm, "_rel"}, z);
   endtask

   vec_t tv[$];

   // Reference model: tag -> owner (-1 free, 0 dcache, 1 icache).
   int own[16];
   int starve;
   bit merr;

   initial begin
      vec_t v;
      logic [63:0] dbf;
      dbf = 64'hDEADBEEF_CAFEF00D;
      drive(mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0));
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Directed vectors. Counts and err are the registered values seen
      // before the edge on which the vector is applied.
      tv.push_back(mk(0,0,0, 0,0, 0,0,0,   0,0,0, 0,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(1,'h1000,0, 0,0, 3,0,0, 1,'h1000,0, 3,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(0,0,0, 0,0, 0,3,dbf, 0,0,0, 0,0, 3,dbf,0,0, 1,0,0));
      tv.push_back(mk(0,0,0, 0,0, 0,0,0,   0,0,0, 0,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(2,'h2008,'h1111, 0,0, 5,0,0, 2,'h2008,'h1111, 5,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(0,0,0, 1,'h3000, 6,0,0, 1,'h3000,0, 0,6, 0,0,0,0, 1,0,0));
      tv.push_back(mk(0,0,0, 0,0, 0,6,'h66, 0,0,0, 0,0, 0,0,6,'h66, 1,1,0));
      tv.push_back(mk(0,0,0, 0,0, 0,5,'h55, 0,0,0, 0,0, 5,'h55,0,0, 1,0,0));
      tv.push_back(mk(1,'h4000,0, 0,0, 7,0,0, 1,'h4000,0, 7,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(0,0,0, 1,'h5000, 7,7,'h77, 1,'h5000,0, 0,7, 7,'h77,0,0, 1,0,0));
      tv.push_back(mk(0,0,0, 0,0, 0,0,0,   0,0,0, 0,0, 0,0,0,0, 0,1,0));
      tv.push_back(mk(0,0,0, 0,0, 0,7,'h70, 0,0,0, 0,0, 0,0,7,'h70, 0,1,0));
      tv.push_back(mk(0,0,0, 0,0, 0,9,'h99, 0,0,0, 0,0, 0,0,0,0, 0,0,0));
      tv.push_back(mk(0,0,0, 0,0, 0,0,0,   0,0,0, 0,0, 0,0,0,0, 0,0,1));
      tv.push_back(mk(1,'h6000,0, 0,0, 0,0,0, 1,'h6000,0, 0,0, 0,0,0,0, 0,0,1));
      tv.push_back(mk(0,0,0, 0,0, 4,0,0,   0,0,0, 0,0, 0,0,0,0, 0,0,1));
      tv.push_back(mk(0,0,0, 0,0, 0,4,'h44, 0,0,0, 0,0, 0,0,0,0, 0,0,1));
      tv.push_back(mk(0,0,0, 0,0, 0,0,0,   0,0,0, 0,0, 0,0,0,0, 0,0,1));

      do_reset("reset");
      foreach (tv[i]) begin
         @(negedge clock);
         drive(tv[i]);
         #1 check_vec($sformatf("vec%0d", i), tv[i]);
      end

      // A reset clears the sticky error.
      do_reset("err_clear");

      // Starvation: both caches request every cycle and memory rejects.
      // icache must win on cycles 4 and 9.
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         dcmd = 2'd1; daddr = 32'hA000 + c; icmd = 2'd1; iaddr = 32'hB000 + c;
         mresp = 0; mtag = 0;
         #1;
         chk($sformatf("starve_c%0d", c), 64'(p_addr),
             (c == 4 || c == 9) ? 64'(32'hB000 + c) : 64'(32'hA000 + c));
      end

      // A completion arriving after a mid-operation reset is dropped.
      do_reset("mid_rst0");
      @(negedge clock);
      drive(mk(1,'h7000,0, 0,0, 2,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0));
      @(negedge clock);
      drive(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0));
      #1 chk("mid_rst_cnt_pre", 64'(d_out), 64'd1);
      reset = 1'b0;
      #1 chk("mid_rst_cnt_clr", 64'(d_out), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      mtag = 4'd2; mdata = 64'h22;
      #1 chk("mid_rst_drop_tag", 64'(d_tag), 64'd0);
      @(negedge clock);
      mtag = 4'd0;
      #1 chk("mid_rst_err", 64'(terr), 64'd1);

      // Randomized traffic against the reference model.
      do_reset("rand_rst");
      for (int t = 0; t < 16; t++) own[t] = -1;
      starve = 0;
      merr = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int live[$];
         bit dreq, ireq, iw, dw;
         int ndc, nic;
         v.dcmd  = 2'($urandom_range(0, 2));
         v.daddr = $urandom & 32'hFFFF_FFF8;
         v.ddata = {$urandom, $urandom};
         v.icmd  = 2'($urandom_range(0, 1));
         v.iaddr = $urandom;
         v.mdata = {$urandom, $urandom};
         v.mresp = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 15)) : 4'd0;
         if (v.mresp != 0 && own[v.mresp] >= 0) v.mresp = 4'($urandom_range(1, 15));
         live.delete();
         for (int t = 1; t < 16; t++) if (own[t] >= 0) live.push_back(t);
         if (live.size() > 0 && $urandom_range(0, 9) < 5)
            v.mtag = 4'(live[$urandom_range(0, live.size() - 1)]);
         else if ($urandom_range(0, 9) < 2)
            v.mtag = 4'($urandom_range(1, 15));
         else
            v.mtag = 4'd0;

         dreq = v.dcmd != 0;
         ireq = v.icmd != 0;
         iw = ireq && (!dreq || starve >= 4);
         dw = dreq && !iw;
         v.pcmd  = dw ? v.dcmd  : iw ? v.icmd  : 2'd0;
         v.paddr = dw ? v.daddr : iw ? v.iaddr : 32'd0;
         v.pdata = dw ? v.ddata : 64'd0;
         v.dresp = dw ? v.mresp : 4'd0;
         v.iresp = iw ? v.mresp : 4'd0;
         v.dtag = 0; v.ddat = 0; v.itag = 0; v.idat = 0;
         if (v.mtag != 0 && own[v.mtag] == 0) begin v.dtag = v.mtag; v.ddat = v.mdata; end
         if (v.mtag != 0 && own[v.mtag] == 1) begin v.itag = v.mtag; v.idat = v.mdata; end
         ndc = 0; nic = 0;
         for (int t = 1; t < 16; t++) begin
            if (own[t] == 0) ndc++;
            if (own[t] == 1) nic++;
         end
         v.dcnt = 4'(ndc); v.icnt = 4'(nic); v.err = merr;

         @(negedge clock);
         drive(v);
         #1 check_vec($sformatf("rand%0d", cyc), v);

         if (v.mtag != 0) begin
            if (own[v.mtag] >= 0) own[v.mtag] = -1;
            else merr = 1;
         end
         if ((dw || iw) && v.mresp != 0) begin
            if (own[v.mresp] >= 0) merr = 1;
            own[v.mresp] = iw ? 1 : 0;
         end
         starve = (ireq && !iw) ? ((starve < 15) ? starve + 1 : 15) : 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
